robo_ambiente: RTL and testbench



---
 rtl/robo_ambiente_pkg.sv | 39 +++
 rtl/robo_amb_lookup.sv | 68 ++++++
 rtl/robo_ambiente.sv | 175 +++++++++++++++++
 tb/tb_robo_ambiente.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/robo_ambiente_pkg.sv
// Shared definitions for the robo_ambiente grid-world model.
// Latency: n/a (types, constants and a pose-stepping helper only).
// Backpressure: n/a.
// Contents: ACTIVE level, heading codes DIR_*, FSM state codes AMB_*,
//           packed pose_t and step_pose() (one cell forward along heading).
package robo_ambiente_pkg;

    localparam logic ACTIVE = 1'b1;

    // Headings: N increments y, E increments x, S decrements y, W decrements x.
    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    localparam logic [1:0] AMB_IDLE    = 2'd0;
    localparam logic [1:0] AMB_MOVE    = 2'd1;
    localparam logic [1:0] AMB_TURN    = 2'd2;
    localparam logic [1:0] AMB_COLLECT = 2'd3;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] dir;
    } pose_t;

    function automatic pose_t step_pose(input pose_t p);
        pose_t n;
        n = p;
        case (p.dir)
            DIR_N: n.y = p.y + 4'd1;
            DIR_E: n.x = p.x + 4'd1;
            DIR_S: n.y = p.y - 4'd1;
            DIR_W: n.x = p.x - 4'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/robo_amb_lookup.sv
// Combinational sensor decode: ahead/left cells from pose, bounds, bitmap lookups.
// Latency: 0 cycles (pure combinational, driven only by registered pose/debris).
// Backpressure: none.
// Ports: i_pose (x,y,dir), i_wall/i_debris/i_mark (W*H bitmaps, bit = y*W+x);
//        o_ahead_idx (bitmap index of the cell ahead), o_head, o_left, o_barrier, o_under.
module robo_amb_lookup
    import robo_ambiente_pkg::*;
#(
    parameter int W = 4,
    parameter int H = 4
) (
    input  pose_t            i_pose,
    input  logic [W*H-1:0]   i_wall,
    input  logic [W*H-1:0]   i_debris,
    input  logic [W*H-1:0]   i_mark,
    output logic [7:0]       o_ahead_idx,
    output logic             o_head,
    output logic             o_left,
    output logic             o_barrier,
    output logic             o_under
);

    localparam logic signed [5:0] WS = 6'(W);
    localparam logic signed [5:0] HS = 6'(H);
    localparam logic [7:0]        W8 = 8'(W);

    // Signed coordinates so that stepping off the 0 edge reads as -1, not 15.
    logic signed [5:0] w_px, w_py, w_ax, w_ay, w_lx, w_ly;
    logic              w_a_in, w_l_in;
    logic [7:0]        w_a_idx, w_l_idx, w_p_idx;
    logic [255:0]      w_wall, w_deb, w_mark;

    assign w_px = $signed({2'b00, i_pose.x});
    assign w_py = $signed({2'b00, i_pose.y});

    // Left of the robot is one quarter-turn counter-clockwise from its heading.
    always_comb begin
        w_ax = w_px;
        w_ay = w_py;
        w_lx = w_px;
        w_ly = w_py;
        case (i_pose.dir)
            DIR_N: begin w_ay = w_py + 6'sd1; w_lx = w_px - 6'sd1; end
            DIR_E: begin w_ax = w_px + 6'sd1; w_ly = w_py + 6'sd1; end
            DIR_S: begin w_ay = w_py - 6'sd1; w_lx = w_px + 6'sd1; end
            DIR_W: begin w_ax = w_px - 6'sd1; w_ly = w_py - 6'sd1; end
        endcase
    end

    assign w_a_in = (w_ax >= 6'sd0) && (w_ax < WS) && (w_ay >= 6'sd0) && (w_ay < HS);
    assign w_l_in = (w_lx >= 6'sd0) && (w_lx < WS) && (w_ly >= 6'sd0) && (w_ly < HS);

    // Indices are only meaningful when the matching in-bounds flag is set.
    assign w_a_idx = 8'(w_ay[3:0]) * W8 + 8'(w_ax[3:0]);
    assign w_l_idx = 8'(w_ly[3:0]) * W8 + 8'(w_lx[3:0]);
    assign w_p_idx = 8'(i_pose.y) * W8 + 8'(i_pose.x);

    assign w_wall = 256'(i_wall);
    assign w_deb  = 256'(i_debris);
    assign w_mark = 256'(i_mark);

    assign o_ahead_idx = w_a_idx;
    assign o_head      = !w_a_in || w_wall[w_a_idx];
    assign o_left      = !w_l_in || w_wall[w_l_idx];
    assign o_barrier   = w_a_in && w_deb[w_a_idx];
    assign o_under     = w_mark[w_p_idx];

endmodule

// File: rtl/robo_ambiente.sv
// Grid-world model closing the loop around the collector robot (pose, debris, sensors).
// Latency: advance/turn/collect take MOVE/TURN/COLLECT_CYCLES busy cycles after the IDLE sample.
// Backpressure: commands are sampled only while busy=0; refused advances pulse bump.
// Ports: clock, reset (sync, active-high); advance/turn/collect in; head/left/barrier/under,
//        busy, bump, pos_x/pos_y/heading out. Defining ROBO_AMB_STATS_EN adds
//        moves_cnt/turns_cnt/bumps_cnt (saturating) and debris_left (popcount of debris).
module robo_ambiente
    import robo_ambiente_pkg::*;
#(
    parameter int             W              = 4,
    parameter int             H              = 4,
    parameter logic [W*H-1:0] WALL_MAP       = '0,
    parameter logic [W*H-1:0] DEBRIS_MAP     = '0,
    parameter logic [W*H-1:0] MARK_MAP       = '0,
    parameter int             START_X        = 0,
    parameter int             START_Y        = 0,
    parameter int             START_DIR      = 0,
    parameter int             MOVE_CYCLES    = 2,
    parameter int             TURN_CYCLES    = 2,
    parameter int             COLLECT_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        advance,
    input  logic        turn,
    input  logic        collect,
    output logic        head,
    output logic        left,
    output logic        barrier,
    output logic        under,
    output logic        busy,
    output logic        bump,
    output logic [3:0]  pos_x,
    output logic [3:0]  pos_y,
    output logic [1:0]  heading
`ifdef ROBO_AMB_STATS_EN
    ,
    output logic [15:0] moves_cnt,
    output logic [15:0] turns_cnt,
    output logic [15:0] bumps_cnt,
    output logic [7:0]  debris_left
`endif
);

    localparam pose_t      START_POSE = {4'(START_X), 4'(START_Y), 2'(START_DIR)};
    localparam logic [7:0] MOVE_LD    = 8'(MOVE_CYCLES - 1);
    localparam logic [7:0] TURN_LD    = 8'(TURN_CYCLES - 1);
    localparam logic [7:0] COL_LD     = 8'(COLLECT_CYCLES - 1);

    pose_t          r_pose;
    logic [1:0]     r_state;
    logic [7:0]     r_cnt;
    logic [W*H-1:0] r_debris;
    logic           r_bump;

    logic [7:0]     w_ahead_idx;
    logic           w_head, w_left, w_barrier, w_under;
    logic           w_idle, w_move_done, w_turn_done, w_bump_req;

    robo_amb_lookup #(.W(W), .H(H)) u_lookup (
        .i_pose      (r_pose),
        .i_wall      (WALL_MAP),
        .i_debris    (r_debris),
        .i_mark      (MARK_MAP),
        .o_ahead_idx (w_ahead_idx),
        .o_head      (w_head),
        .o_left      (w_left),
        .o_barrier   (w_barrier),
        .o_under     (w_under)
    );

    assign w_idle      = (r_state == AMB_IDLE);
    assign w_move_done = (r_state == AMB_MOVE) && (r_cnt == 8'd0);
    assign w_turn_done = (r_state == AMB_TURN) && (r_cnt == 8'd0);
    // Advance loses to collect and turn, so only a lone advance can be refused.
    assign w_bump_req  = w_idle && (collect != ACTIVE) && (turn != ACTIVE) &&
                         (advance == ACTIVE) && (w_head || w_barrier);

    always_ff @(posedge clock) begin
        if (reset == ACTIVE) begin
            r_pose   <= START_POSE;
            r_debris <= DEBRIS_MAP;
            r_state  <= AMB_IDLE;
            r_cnt    <= 8'd0;
            r_bump   <= 1'b0;
        end else begin
            r_bump <= w_bump_req;
            case (r_state)
                AMB_IDLE: begin
                    if (collect == ACTIVE) begin
                        // Collecting in front of an empty cell is a silent no-op.
                        if (w_barrier) begin
                            r_state <= AMB_COLLECT;
                            r_cnt   <= COL_LD;
                        end
                    end else if (turn == ACTIVE) begin
                        r_state <= AMB_TURN;
                        r_cnt   <= TURN_LD;
                    end else if ((advance == ACTIVE) && !w_head && !w_barrier) begin
                        r_state <= AMB_MOVE;
                        r_cnt   <= MOVE_LD;
                    end
                end
                AMB_MOVE: begin
                    if (w_move_done) begin
                        r_pose  <= step_pose(r_pose);
                        r_state <= AMB_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                AMB_TURN: begin
                    if (w_turn_done) begin
                        r_pose.dir <= r_pose.dir + 2'd1;
                        r_state    <= AMB_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                AMB_COLLECT: begin
                    // Pose and debris are frozen while collecting, so the ahead
                    // index still names the cell that held debris on entry.
                    if (r_cnt == 8'd0) begin
                        for (int i = 0; i < W*H; i++) begin
                            if (8'(i) == w_ahead_idx) r_debris[i] <= 1'b0;
                        end
                        r_state <= AMB_IDLE;
                    end else if (collect != ACTIVE) begin
                        r_state <= AMB_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
            endcase
        end
    end

    assign head    = w_head;
    assign left    = w_left;
    assign barrier = w_barrier;
    assign under   = w_under;
    assign busy    = !w_idle;
    assign bump    = r_bump;
    assign pos_x   = r_pose.x;
    assign pos_y   = r_pose.y;
    assign heading = r_pose.dir;

`ifdef ROBO_AMB_STATS_EN
    logic [15:0] r_moves, r_turns, r_bumps;
    logic [7:0]  w_pop;

    always_ff @(posedge clock) begin
        if (reset == ACTIVE) begin
            r_moves <= 16'd0;
            r_turns <= 16'd0;
            r_bumps <= 16'd0;
        end else begin
            if (w_move_done && (r_moves != 16'hFFFF)) r_moves <= r_moves + 16'd1;
            if (w_turn_done && (r_turns != 16'hFFFF)) r_turns <= r_turns + 16'd1;
            if (w_bump_req  && (r_bumps != 16'hFFFF)) r_bumps <= r_bumps + 16'd1;
        end
    end

    always_comb begin
        w_pop = 8'd0;
        for (int i = 0; i < W*H; i++) w_pop = w_pop + 8'(r_debris[i]);
    end

    assign moves_cnt   = r_moves;
    assign turns_cnt   = r_turns;
    assign bumps_cnt   = r_bumps;
    assign debris_left = w_pop;
`endif

endmodule

// File: tb/tb_robo_ambiente.sv
// Self-checking bench for robo_ambiente on a 4x4 grid: wall at (2,0), debris and mark at (0,1).
// Latency: each command step waits (bounded) until busy falls, then pops its expectation.
// Backpressure: commands are only applied while the DUT is idle.
module tb_robo_ambiente;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       advance = 1'b0, turn = 1'b0, collect = 1'b0;
    logic       head, left, barrier, under, busy, bump;
    logic [3:0] pos_x, pos_y;
    logic [1:0] heading;
`ifdef ROBO_AMB_STATS_EN
    logic [15:0] moves_cnt, turns_cnt, bumps_cnt;
    logic [7:0]  debris_left;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       a, t, c;
        int         hold;
        logic [3:0] x, y;
        logic [1:0] d;
        int         busy;
        logic       bmp, und, bar;
    } step_t;

    step_t sb_q[$];

    always #5 clock = ~clock;

    robo_ambiente #(
        .W(4), .H(4),
        .WALL_MAP(16'h0004), .DEBRIS_MAP(16'h0010), .MARK_MAP(16'h0010),
        .START_X(0), .START_Y(0), .START_DIR(0),
        .MOVE_CYCLES(2), .TURN_CYCLES(2), .COLLECT_CYCLES(4)
    ) dut (
        .clock(clock), .reset(reset),
        .advance(advance), .turn(turn), .collect(collect),
        .head(head), .left(left), .barrier(barrier), .under(under),
        .busy(busy), .bump(bump),
        .pos_x(pos_x), .pos_y(pos_y), .heading(heading)
`ifdef ROBO_AMB_STATS_EN
        , .moves_cnt(moves_cnt), .turns_cnt(turns_cnt),
        .bumps_cnt(bumps_cnt), .debris_left(debris_left)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic step_t mk(logic a, logic t, logic c, int hold, int x, int y, int d,
                                 int bsy, logic bmp, logic und, logic bar);
        step_t s;
        s.a = a; s.t = t; s.c = c; s.hold = hold;
        s.x = 4'(x); s.y = 4'(y); s.d = 2'(d);
        s.busy = bsy; s.bmp = bmp; s.und = und; s.bar = bar;
        return s;
    endfunction

    // Apply a command for hold_cycles sampling edges, count busy cycles until idle
    // (bounded at 40; an expired bound shows up as a busy-count mismatch).
    task automatic drive_cmd(input logic a, input logic t, input logic c, input int hold_cycles,
                             output int bc, output logic bs);
        advance = a; turn = t; collect = c;
        bc = 0; bs = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i + 1 >= hold_cycles) begin
                advance = 1'b0; turn = 1'b0; collect = 1'b0;
            end
            if (bump) bs = 1'b1;
            if (busy) bc++;
            else break;
        end
        advance = 1'b0; turn = 1'b0; collect = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        n_checks++;
        if ({pos_x, pos_y, heading} !== {4'd0, 4'd0, 2'd0}) begin
            n_fail++; $display("FAIL reset_pose got=%0d,%0d,%0d want=0,0,0", pos_x, pos_y, heading);
        end
        n_checks++;
        if ({busy, bump} !== 2'b00) begin
            n_fail++; $display("FAIL reset_busy_bump got=%b%b want=00", busy, bump);
        end
        n_checks++;
        if ({head, left, barrier, under} !== 4'b0110) begin
            n_fail++; $display("FAIL reset_sensors got=%b%b%b%b want=0110", head, left, barrier, under);
        end
    endtask

    task automatic test_collect();
        step_t s[$];
        int bc; logic bs;
        s.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1)); // advance into debris: bump
        s.push_back(mk(0, 0, 1, 2, 0, 0, 0, 2, 0, 0, 1)); // released early: aborted
        s.push_back(mk(0, 0, 1, 4, 0, 0, 0, 4, 0, 0, 0)); // held long enough: cleared
        s.push_back(mk(0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0)); // nothing ahead: no-op
        foreach (s[k]) begin
            step_t e;
            sb_q.push_back(s[k]);
            drive_cmd(s[k].a, s[k].t, s[k].c, s[k].hold, bc, bs);
            e = sb_q.pop_front();
            n_checks++;
            if ({pos_x, pos_y, heading, bs, under, barrier} !== {e.x, e.y, e.d, e.bmp, e.und, e.bar} || bc != e.busy) begin
                n_fail++;
                $display("FAIL collect[%0d] got x=%0d y=%0d dir=%0d busy=%0d bump=%b under=%b barrier=%b want x=%0d y=%0d dir=%0d busy=%0d bump=%b under=%b barrier=%b",
                         k, pos_x, pos_y, heading, bc, bs, under, barrier, e.x, e.y, e.d, e.busy, e.bmp, e.und, e.bar);
            end
        end
    endtask

    task automatic test_move();
        step_t s[$];
        int bc; logic bs;
        s.push_back(mk(1, 0, 0, 1, 0, 1, 0, 2, 0, 1, 0));
        s.push_back(mk(1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 1, 0, 3, 0, 2, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 1, 0, 3, 0, 0, 1, 0, 0)); // top edge: bump
        foreach (s[k]) begin
            step_t e;
            sb_q.push_back(s[k]);
            drive_cmd(s[k].a, s[k].t, s[k].c, s[k].hold, bc, bs);
            e = sb_q.pop_front();
            n_checks++;
            if ({pos_x, pos_y, heading, bs, under, barrier} !== {e.x, e.y, e.d, e.bmp, e.und, e.bar} || bc != e.busy) begin
                n_fail++;
                $display("FAIL move[%0d] got x=%0d y=%0d dir=%0d busy=%0d bump=%b under=%b barrier=%b want x=%0d y=%0d dir=%0d busy=%0d bump=%b under=%b barrier=%b",
                         k, pos_x, pos_y, heading, bc, bs, under, barrier, e.x, e.y, e.d, e.busy, e.bmp, e.und, e.bar);
            end
        end
        tick();
        n_checks++;
        if (bump !== 1'b0) begin
            n_fail++; $display("FAIL bump_one_cycle got=%b want=0", bump);
        end
        n_checks++;
        if ({head, left} !== 2'b11) begin
            n_fail++; $display("FAIL edge_sensors got=%b%b want=11", head, left);
        end
    endtask

    task automatic test_turn();
        step_t s[$];
        int bc; logic bs;
        s.push_back(mk(0, 1, 0, 1, 0, 3, 1, 2, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 1, 0, 3, 2, 2, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 1, 0, 3, 3, 2, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 1, 0, 3, 0, 2, 0, 0, 0));
        s.push_back(mk(1, 1, 0, 1, 0, 3, 1, 2, 0, 0, 0)); // turn wins over advance
        foreach (s[k]) begin
            step_t e;
            sb_q.push_back(s[k]);
            drive_cmd(s[k].a, s[k].t, s[k].c, s[k].hold, bc, bs);
            e = sb_q.pop_front();
            n_checks++;
            if ({pos_x, pos_y, heading, bs, under, barrier} !== {e.x, e.y, e.d, e.bmp, e.und, e.bar} || bc != e.busy) begin
                n_fail++;
                $display("FAIL turn[%0d] got x=%0d y=%0d dir=%0d busy=%0d bump=%b under=%b barrier=%b want x=%0d y=%0d dir=%0d busy=%0d bump=%b under=%b barrier=%b",
                         k, pos_x, pos_y, heading, bc, bs, under, barrier, e.x, e.y, e.d, e.busy, e.bmp, e.und, e.bar);
            end
        end
        n_checks++;
        if ({head, left} !== 2'b01) begin
            n_fail++; $display("FAIL east_sensors got=%b%b want=01", head, left);
        end
    endtask

    task automatic test_wall();
        step_t s[$];
        int bc; logic bs;
        s.push_back(mk(0, 1, 0, 1, 0, 3, 2, 2, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 1, 0, 2, 2, 2, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 1, 0, 1, 2, 2, 0, 1, 0));
        s.push_back(mk(1, 0, 0, 1, 0, 0, 2, 2, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 1, 0, 0, 3, 2, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 1, 0, 0, 0, 2, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 1, 0, 0, 1, 2, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 1, 1, 0, 1, 2, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0)); // wall at (2,0): bump
        s.push_back(mk(0, 1, 0, 1, 1, 0, 2, 2, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 1, 1, 0, 3, 2, 0, 0, 0));
        foreach (s[k]) begin
            step_t e;
            sb_q.push_back(s[k]);
            drive_cmd(s[k].a, s[k].t, s[k].c, s[k].hold, bc, bs);
            e = sb_q.pop_front();
            n_checks++;
            if ({pos_x, pos_y, heading, bs, under, barrier} !== {e.x, e.y, e.d, e.bmp, e.und, e.bar} || bc != e.busy) begin
                n_fail++;
                $display("FAIL wall[%0d] got x=%0d y=%0d dir=%0d busy=%0d bump=%b under=%b barrier=%b want x=%0d y=%0d dir=%0d busy=%0d bump=%b under=%b barrier=%b",
                         k, pos_x, pos_y, heading, bc, bs, under, barrier, e.x, e.y, e.d, e.busy, e.bmp, e.und, e.bar);
            end
        end
        n_checks++;
        if ({head, left} !== 2'b01) begin
            n_fail++; $display("FAIL west_sensors got=%b%b want=01", head, left);
        end
    endtask

    // Reset lands on the very edge where the move would have completed.
    task automatic test_reset_mid();
        advance = 1'b1;
        tick();
        advance = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_busy got=%b want=1", busy);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({pos_x, pos_y, heading} !== {4'd0, 4'd0, 2'd0}) begin
            n_fail++; $display("FAIL mid_reset_pose got=%0d,%0d,%0d want=0,0,0", pos_x, pos_y, heading);
        end
        n_checks++;
        if ({busy, bump, barrier} !== 3'b001) begin
            n_fail++; $display("FAIL mid_reset_state got busy=%b bump=%b barrier=%b want 0 0 1", busy, bump, barrier);
        end
    endtask

`ifdef ROBO_AMB_STATS_EN
    task automatic test_stats();
        step_t s[$];
        int bc; logic bs;
        n_checks++;
        if (debris_left !== 8'd1) begin
            n_fail++; $display("FAIL stats_debris_init got=%0d want=1", debris_left);
        end
        s.push_back(mk(0, 0, 1, 4, 0, 0, 0, 4, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 1, 0, 1, 0, 2, 0, 1, 0));
        s.push_back(mk(1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 1, 0, 3, 0, 2, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 1, 0, 3, 0, 0, 1, 0, 0));
        s.push_back(mk(0, 1, 0, 1, 0, 3, 1, 2, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 1, 0, 3, 2, 2, 0, 0, 0));
        foreach (s[k]) begin
            step_t e;
            sb_q.push_back(s[k]);
            drive_cmd(s[k].a, s[k].t, s[k].c, s[k].hold, bc, bs);
            e = sb_q.pop_front();
            n_checks++;
            if ({pos_x, pos_y, heading, bs, under, barrier} !== {e.x, e.y, e.d, e.bmp, e.und, e.bar} || bc != e.busy) begin
                n_fail++;
                $display("FAIL stats[%0d] got x=%0d y=%0d dir=%0d busy=%0d bump=%b under=%b barrier=%b want x=%0d y=%0d dir=%0d busy=%0d bump=%b under=%b barrier=%b",
                         k, pos_x, pos_y, heading, bc, bs, under, barrier, e.x, e.y, e.d, e.busy, e.bmp, e.und, e.bar);
            end
        end
        n_checks++;
        if ({moves_cnt, turns_cnt, bumps_cnt, debris_left} !== {16'd3, 16'd2, 16'd1, 8'd0}) begin
            n_fail++;
            $display("FAIL stats_counts got moves=%0d turns=%0d bumps=%0d debris=%0d want 3 2 1 0",
                     moves_cnt, turns_cnt, bumps_cnt, debris_left);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_collect();
        test_move();
        test_turn();
        test_wall();
        test_reset_mid();
`ifdef ROBO_AMB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
